// File: rtl/wrr_vchanel_scheduler_if.sv
// rtl/wrr_vchanel_scheduler_if.sv - VC FIFO status, weights and grant outputs of the WRR scheduler
interface wrr_vchanel_scheduler_if #(
  parameter int WEIGHT_W = 4
);
  logic                enb;
  logic                empty_vchanel0;
  logic                empty_vchanel1;
  logic                empty_vchanel2;
  logic                empty_vchanel3;
  logic                almost_full_out;
  logic [WEIGHT_W-1:0] weight0;
  logic [WEIGHT_W-1:0] weight1;
  logic [WEIGHT_W-1:0] weight2;
  logic [WEIGHT_W-1:0] weight3;
  logic [1:0]          arbiter;
  logic                pop_vchanel0;
  logic                pop_vchanel1;
  logic                pop_vchanel2;
  logic                pop_vchanel3;
  logic                valid_out;

  modport master (
    input  enb, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    input  almost_full_out, weight0, weight1, weight2, weight3,
    output arbiter, pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3, valid_out
  );

  modport slave (
    output enb, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    output almost_full_out, weight0, weight1, weight2, weight3,
    input  arbiter, pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3, valid_out
  );
endinterface

// File: rtl/wrr_vchanel_scheduler.sv
// rtl/wrr_vchanel_scheduler.sv - weighted round-robin pop scheduler for four VC FIFOs
// Optional per-channel saturating pop counters when WRR_STATS_EN is defined.
module wrr_vchanel_scheduler #(
  parameter int WEIGHT_W = 4,
  parameter int NUM_VC   = 4
) (
  input  logic clk,
  input  logic rst,
  wrr_vchanel_scheduler_if.master bus
`ifdef WRR_STATS_EN
  ,
  output logic [7:0] pop_cnt_vchanel0,
  output logic [7:0] pop_cnt_vchanel1,
  output logic [7:0] pop_cnt_vchanel2,
  output logic [7:0] pop_cnt_vchanel3
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                valid_q;

  logic [NUM_VC-1:0]   empty;
  logic [NUM_VC-1:0]   eligible;
  logic [NUM_VC-1:0]   pop;
  logic [WEIGHT_W-1:0] weight [NUM_VC];
  logic [1:0]          next_ch;
  logic                any_elig;
  logic                grant_pop;
  logic                rotate;

  assign empty     = {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
  assign weight[0] = bus.weight0;
  assign weight[1] = bus.weight1;
  assign weight[2] = bus.weight2;
  assign weight[3] = bus.weight3;

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      eligible[i] = !empty[i] && (weight[i] != '0);
    end
  end

  // Descending scan so the nearest channel after ptr wins; offset NUM_VC wraps to ptr itself.
  always_comb begin
    next_ch  = ptr_q;
    any_elig = 1'b0;
    for (int k = NUM_VC; k >= 1; k--) begin
      if (eligible[ptr_q + 2'(k)]) begin
        next_ch  = ptr_q + 2'(k);
        any_elig = 1'b1;
      end
    end
  end

  assign grant_pop = bus.enb && rst && (state_q == GRANT) && !empty[ptr_q] &&
                     (credit_q != '0) && !bus.almost_full_out;
  assign pop       = grant_pop ? ({{(NUM_VC-1){1'b0}}, 1'b1} << ptr_q) : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    rotate   = 1'b0;
    if (bus.enb) begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_d  = GRANT;
            ptr_d    = next_ch;
            credit_d = weight[next_ch];
          end
        end
        GRANT: begin
          if (grant_pop) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end
          // An emptied channel forfeits the rest of its turn, even under backpressure.
          rotate = (grant_pop && (credit_q == WEIGHT_W'(1))) || empty[ptr_q];
          if (rotate) begin
            if (any_elig) begin
              ptr_d    = next_ch;
              credit_d = weight[next_ch];
            end else begin
              state_d  = IDLE;
              credit_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      credit_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      valid_q  <= |pop;
    end
  end

  assign bus.arbiter      = ptr_q;
  assign bus.valid_out    = valid_q;
  assign bus.pop_vchanel0 = pop[0];
  assign bus.pop_vchanel1 = pop[1];
  assign bus.pop_vchanel2 = pop[2];
  assign bus.pop_vchanel3 = pop[3];

`ifdef WRR_STATS_EN
  logic [7:0] pop_cnt [NUM_VC];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VC; i++) pop_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (pop[i] && (pop_cnt[i] != 8'hFF)) pop_cnt[i] <= pop_cnt[i] + 8'd1;
      end
    end
  end

  assign pop_cnt_vchanel0 = pop_cnt[0];
  assign pop_cnt_vchanel1 = pop_cnt[1];
  assign pop_cnt_vchanel2 = pop_cnt[2];
  assign pop_cnt_vchanel3 = pop_cnt[3];
`endif

endmodule

// File: doc/wrr_vchanel_scheduler.md
Name: wrr_vchanel_scheduler

Overview:
- Weighted round-robin scheduler for four virtual-channel FIFOs.
- Drives the 2-bit channel select and the per-channel pop strobes to the output mux, so that mux registers the popped FIFO head.
- Sits between the VC FIFOs (empty flags in) and the downstream output FIFO (almost-full backpressure in).
- Grants each non-empty channel up to its weight in consecutive pops, then rotates.

Parameters:
- WEIGHT_W, 4, width of each weight input and of the credit counter.
- NUM_VC, 4, number of virtual channels; fixed at 4, not to be overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
- enb  in  1  scheduler enable; 0 freezes state and forces all pops to 0.
- empty_vchanel0..3  in  1 each  FIFO empty flags.
- almost_full_out  in  1  downstream backpressure; 1 blocks all pops.
- weight0..3  in  WEIGHT_W each  pops per turn for channel N; 0 = channel never served.
- arbiter  out  2  registered channel select to the output mux.
- pop_vchanel0..3  out  1 each  FIFO read strobes, one-hot or all-zero.
- valid_out  out  1  high the cycle the output mux presents popped data.

Behaviour:
- State registers: state {IDLE, GRANT}, ptr[1:0] (drives arbiter), credit[WEIGHT_W-1:0], valid_out.
- Reset (rst==0): state=IDLE, ptr=0, credit=0, valid_out=0.
  - pops=0 combinationally while rst==0.
  - Reset mid-grant abandons the remaining credit; no pop in the reset cycle.
- eligible(N) = !empty_vchanelN && weightN!=0.
- next_ch = first eligible channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
- Each pop_vchanelN is combinational:
  - pop_vchanelN = enb && rst && state==GRANT && ptr==N && !empty_vchanelN && credit!=0 && !almost_full_out.
- IDLE:
  - If enb and any channel is eligible: ptr<=next_ch, credit<=weight[next_ch], state<=GRANT.
  - No pop in this cycle, so grant-to-first-pop latency is 1 cycle.
- GRANT, on a pop cycle, credit<=credit-1.
- Rotation, in GRANT, when either condition below holds:
  - Conditions: (pop && credit==1), or channel ptr empty (current cycle).
  - If any channel is eligible: ptr<=next_ch, credit<=weight[next_ch]; stay in GRANT.
  - The turn of a channel that empties early is forfeited; its unused credit is not carried over.
  - If no channel is eligible: state<=IDLE, credit<=0.
- Back-to-back pops across a rotation are allowed: the new channel pops in the cycle after the last pop of the old one.
- almost_full_out=1:
  - No pops; ptr and credit hold.
  - No rotation, unless the current channel is empty.
- Weights are sampled only at credit load. Changing weightN mid-turn affects channel N's next turn only.
- Single eligible channel: next_ch returns ptr itself, so that channel is served continuously with credit reloaded.
- valid_out <= |pop_vchanel* (registered; 1-cycle latency, aligned with the mux output register).
- enb==0:
  - All pops=0; ptr, credit and state hold.
  - valid_out<=0 next cycle.
- Pops are never one-hot violated.
- A pop is never issued to an empty FIFO or while almost_full_out=1.

Optional Feature:
- Macro: WRR_STATS_EN.
- Defined: adds outputs pop_cnt_vchanel0..3, each 8 bits.
  - Counter N increments on each pop_vchanelN.
  - Saturates at 8'hFF.
  - Cleared by rst==0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with all FIFOs non-empty -> arbiter=0, all pops=0, valid_out=0. Release rst=1 -> first pop on ch1 (search starts at ptr+1) two cycles after release.
- Weights 3,2,1,1, all FIFOs deep and non-empty, almost_full_out=0 -> steady pop sequence 1,1,2,3,0,0,0 repeating (ch1 x2, ch2 x1, ch3 x1, ch0 x3). valid_out follows each pop by 1 cycle.
- Weights 4,4,4,4, ch2 holding only 2 words -> ch2 popped twice, then its turn is forfeited and ptr moves to ch3 with credit 4. No pop is issued while empty_vchanel2=1.
- almost_full_out=1 for 5 cycles in the middle of a ch0 turn (credit 2 left) -> zero pops, ptr=0 and credit=2 held. After release, exactly 2 more ch0 pops, then rotation.
- Weight1=0 with ch1 non-empty, others empty -> no pops ever and state stays IDLE. Then ch3 becomes non-empty -> ch3 is served.
- With WRR_STATS_EN, 300 pops on ch0 -> pop_cnt_vchanel0=8'hFF, other counters unchanged. A reset pulse clears all counters to 0.
